// File: rtl/pdcache_pkg.sv
// pdcache shared types and address helpers.
// Line geometry is fixed at 32 bytes; set count comes from the instance.
package pdcache_pkg;

  localparam int LINE_W = 256;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    FLUSH_SCAN,
    FLUSH_WB
  } pdcache_state_t;

  function automatic logic [31:0] tag_of(
    input logic [31:0] addr,
    input int          idx_w
  );
    return addr >> (5 + idx_w);
  endfunction

  function automatic logic [31:0] idx_of(
    input logic [31:0] addr,
    input int          idx_w
  );
    return (addr >> 5) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [2:0] word_of(
    input logic [31:0] addr
  );
    return addr[4:2];
  endfunction

endpackage

// File: rtl/pdcache_plru.sv
// Tree-PLRU for one set: heap-ordered nodes, root is node 0.
// Node bit 0 points the victim into the lower-index subtree.
module pdcache_plru #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         bits,
  input  logic [$clog2(WAYS)-1:0] way,
  output logic [WAYS-2:0]         bits_next,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int WAY_W = $clog2(WAYS);

  // Walk the accessed way's path, pointing each node away from it.
  always_comb begin
    logic [WAY_W-1:0] ni;
    logic [WAY_W-1:0] ws;
    logic             b;
    bits_next = bits;
    ni = '0;
    ws = way;
    for (int l = 0; l < WAY_W; l++) begin
      b = ws[WAY_W-1];
      bits_next[ni] = ~b;
      ws = ws << 1;
      ni = WAY_W'((32'(ni) << 1) + 32'd1 + 32'(b));
    end
  end

  // Follow the node bits from the root to find the victim leaf.
  always_comb begin
    logic [WAY_W-1:0] ni;
    logic             b;
    victim = '0;
    ni = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b = bits[ni];
      victim = WAY_W'((32'(victim) << 1) | 32'(b));
      ni = WAY_W'((32'(ni) << 1) + 32'd1 + 32'(b));
    end
  end

endmodule

// File: rtl/pdcache.sv
// Blocking write-back, write-allocate data cache with flush/clean.
// Flop-array storage, tree-PLRU replacement, 256-bit line port.
import pdcache_pkg::*;

module pdcache #(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ufp_addr,
  input  logic [3:0]        ufp_rmask,
  input  logic [3:0]        ufp_wmask,
  input  logic [31:0]       ufp_wdata,
  output logic [31:0]       ufp_rdata,
  output logic              ufp_resp,
  output logic [31:0]       dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [LINE_W-1:0] dfp_wdata,
  input  logic [LINE_W-1:0] dfp_rdata,
  input  logic              dfp_resp,
  input  logic              flush_req,
  output logic              flush_done
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 5 - IDX_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int CNT_W = IDX_W + WAY_W;
  localparam int NODES = WAYS - 1;

  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [NODES-1:0]  plru_q  [SETS];

  pdcache_state_t state;

  logic [31:0]      req_addr;
  logic [3:0]       req_wmask;
  logic [31:0]      req_wdata;
  logic [WAY_W-1:0] victim_q;
  logic [CNT_W-1:0] cnt;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [2:0]        req_word;
  logic [IDX_W-1:0]  scan_idx;
  logic [WAY_W-1:0]  scan_way;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  plru_victim;
  logic [NODES-1:0]  plru_next;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] merged;
  logic [31:0]       hit_word;
  logic [31:0]       byte_en;
  logic              scan_dirty;
  logic              scan_last;
  logic              req_store;

  assign req_tag   = TAG_W'(tag_of(req_addr, IDX_W));
  assign req_idx   = IDX_W'(idx_of(req_addr, IDX_W));
  assign req_word  = word_of(req_addr);
  assign req_store = |req_wmask;
  assign scan_idx  = cnt[CNT_W-1:WAY_W];
  assign scan_way  = cnt[WAY_W-1:0];
  assign scan_last = (cnt == '1);
  assign scan_dirty = valid_q[scan_idx][scan_way]
                    & dirty_q[scan_idx][scan_way];

  // Tag lookup in the requested set.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_idx][w]
          && tag_q[req_idx][w] == req_tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Fill empty ways first, then fall back on PLRU.
  always_comb begin
    logic found;
    found = 1'b0;
    victim = plru_victim;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_idx][w]) begin
        found = 1'b1;
        victim = WAY_W'(w);
      end
    end
  end

  pdcache_plru #(
    .WAYS(WAYS)
  ) u_plru (
    .bits      (plru_q[req_idx]),
    .way       (hit_way),
    .bits_next (plru_next),
    .victim    (plru_victim)
  );

  // Hit word extraction and store byte merge.
  always_comb begin
    hit_line = data_q[req_idx][hit_way];
    hit_word = hit_line[{req_word, 5'b0} +: 32];
    byte_en = {{8{req_wmask[3]}}, {8{req_wmask[2]}},
               {8{req_wmask[1]}}, {8{req_wmask[0]}}};
    merged = hit_line;
    merged[{req_word, 5'b0} +: 32] =
      (hit_word & ~byte_en) | (req_wdata & byte_en);
  end

  assign ufp_resp  = (state == COMPARE) && hit;
  assign ufp_rdata = ufp_resp ? hit_word : '0;

  // Line data and tags: store hits and fills.
  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && req_store) begin
      data_q[req_idx][hit_way] <= merged;
    end else if (state == ALLOCATE && dfp_resp) begin
      data_q[req_idx][victim_q] <= dfp_rdata;
      tag_q[req_idx][victim_q]  <= req_tag;
    end
  end

  // Control FSM, line state bits and registered memory port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_wmask  <= '0;
      req_wdata  <= '0;
      victim_q   <= '0;
      cnt        <= '0;
      dfp_addr   <= '0;
      dfp_read   <= 1'b0;
      dfp_write  <= 1'b0;
      dfp_wdata  <= '0;
      flush_done <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      flush_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if ((|ufp_rmask) || (|ufp_wmask)) begin
            req_addr  <= ufp_addr;
            req_wmask <= ufp_wmask;
            req_wdata <= ufp_wdata;
            state     <= COMPARE;
          end else if (flush_req) begin
            cnt   <= '0;
            state <= FLUSH_SCAN;
          end
        end
        COMPARE: begin
          if (hit) begin
            plru_q[req_idx] <= plru_next;
            if (req_store) begin
              dirty_q[req_idx][hit_way] <= 1'b1;
            end
            state <= IDLE;
          end else begin
            victim_q <= victim;
            if (valid_q[req_idx][victim]
                && dirty_q[req_idx][victim]) begin
              dfp_write <= 1'b1;
              dfp_addr  <= {tag_q[req_idx][victim],
                            req_idx, 5'b0};
              dfp_wdata <= data_q[req_idx][victim];
              state     <= WRITEBACK;
            end else begin
              dfp_read <= 1'b1;
              dfp_addr <= {req_tag, req_idx, 5'b0};
              state    <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (dfp_resp) begin
            dfp_write <= 1'b0;
            dfp_read  <= 1'b1;
            dfp_addr  <= {req_tag, req_idx, 5'b0};
            state     <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (dfp_resp) begin
            dfp_read <= 1'b0;
            dfp_addr <= '0;
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= 1'b0;
            state <= COMPARE;
          end
        end
        FLUSH_SCAN: begin
          if (scan_dirty) begin
            dfp_write <= 1'b1;
            dfp_addr  <= {tag_q[scan_idx][scan_way],
                          scan_idx, 5'b0};
            dfp_wdata <= data_q[scan_idx][scan_way];
            state     <= FLUSH_WB;
          end else if (scan_last) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        FLUSH_WB: begin
          if (dfp_resp) begin
            dfp_write <= 1'b0;
            dfp_addr  <= '0;
            dirty_q[scan_idx][scan_way] <= 1'b0;
            if (scan_last) begin
              flush_done <= 1'b1;
              state      <= IDLE;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= FLUSH_SCAN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdcache.sv
// pdcache bench: directed scenarios plus random traffic on two
// configurations, checked against a flat golden memory model.
module tb_pdcache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         sel;
  logic [31:0]  ufp_addr, ufp_wdata;
  logic [3:0]   ufp_rmask, ufp_wmask;
  logic         flush_req;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  logic [3:0]   rm_b, wm_b, rm_s, wm_s;
  logic         fr_b, fr_s, dresp_b, dresp_s;
  logic [31:0]  rdata_b, rdata_s, daddr_b, daddr_s;
  logic         resp_b, resp_s, dread_b, dread_s;
  logic         dwrite_b, dwrite_s, fdone_b, fdone_s;
  logic [255:0] dwdata_b, dwdata_s;

  assign rm_b    = sel ? 4'h0 : ufp_rmask;
  assign wm_b    = sel ? 4'h0 : ufp_wmask;
  assign rm_s    = sel ? ufp_rmask : 4'h0;
  assign wm_s    = sel ? ufp_wmask : 4'h0;
  assign fr_b    = sel ? 1'b0 : flush_req;
  assign fr_s    = sel ? flush_req : 1'b0;
  assign dresp_b = sel ? 1'b0 : dfp_resp;
  assign dresp_s = sel ? dfp_resp : 1'b0;

  logic [31:0]  rdata, daddr;
  logic         resp, dread, dwrite, fdone;
  logic [255:0] dwdata;
  assign rdata  = sel ? rdata_s  : rdata_b;
  assign resp   = sel ? resp_s   : resp_b;
  assign daddr  = sel ? daddr_s  : daddr_b;
  assign dread  = sel ? dread_s  : dread_b;
  assign dwrite = sel ? dwrite_s : dwrite_b;
  assign dwdata = sel ? dwdata_s : dwdata_b;
  assign fdone  = sel ? fdone_s  : fdone_b;

  pdcache #(.WAYS(4), .SETS(16)) u_big (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_rmask(rm_b), .ufp_wmask(wm_b),
    .ufp_wdata(ufp_wdata), .ufp_rdata(rdata_b), .ufp_resp(resp_b),
    .dfp_addr(daddr_b), .dfp_read(dread_b), .dfp_write(dwrite_b),
    .dfp_wdata(dwdata_b), .dfp_rdata(dfp_rdata), .dfp_resp(dresp_b),
    .flush_req(fr_b), .flush_done(fdone_b)
  );

  pdcache #(.WAYS(2), .SETS(4)) u_small (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_rmask(rm_s), .ufp_wmask(wm_s),
    .ufp_wdata(ufp_wdata), .ufp_rdata(rdata_s), .ufp_resp(resp_s),
    .dfp_addr(daddr_s), .dfp_read(dread_s), .dfp_write(dwrite_s),
    .dfp_wdata(dwdata_s), .dfp_rdata(dfp_rdata), .dfp_resp(dresp_s),
    .flush_req(fr_s), .flush_done(fdone_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] w1;
  } ev_t;

  ev_t          ev_q[$];
  logic [255:0] mem  [bit [31:0]];
  logic [31:0]  gold [bit [31:0]];

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    l = '0;
    if (mem.exists(la)) return mem[la];
    for (int w = 0; w < 8; w++)
      l = {((la + 32'(w * 4)) ^ 32'h5A5A_0000), l[255:32]};
    return l;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] wa);
    logic [255:0] l;
    if (gold.exists(wa)) return gold[wa];
    l = mem_line({wa[31:5], 5'b0});
    return l[{wa[4:2], 5'b0} +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
    input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r = (r & ~(32'hFF << (8 * b)))
                  | (d & (32'hFF << (8 * b)));
    return r;
  endfunction

  function automatic ev_t ev_at(input int i);
    ev_t e;
    e = '0;
    if (i < ev_q.size()) e = ev_q[i];
    return e;
  endfunction

  function automatic int n_writes();
    int n;
    n = 0;
    foreach (ev_q[i]) if (ev_q[i].wr) n++;
    return n;
  endfunction

  // Line memory: fixed latency, one-cycle response pulse.
  initial begin
    int lat;
    lat = 0;
    dfp_resp = 1'b0;
    dfp_rdata = '0;
    forever begin
      @(negedge clk);
      dfp_resp = 1'b0;
      if (dread || dwrite) begin
        if (lat == 2) begin
          lat = 0;
          dfp_resp = 1'b1;
          chk("dfp_align", 64'(daddr[4:0]), 64'h0);
          chk("dfp_excl", 64'(dread & dwrite), 64'h0);
          if (dwrite) begin
            mem[daddr] = dwdata;
            ev_q.push_back({1'b1, daddr, dwdata[63:32]});
          end else begin
            dfp_rdata = mem_line(daddr);
            ev_q.push_back({1'b0, daddr, 32'h0});
          end
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [3:0] rm,
    input logic [3:0] wm, input logic [31:0] wd,
    output logic [31:0] rd, output int lat);
    @(negedge clk);
    ufp_addr = a; ufp_rmask = rm; ufp_wmask = wm; ufp_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp && lat < 300);
    chk($sformatf("resp_%h", a), 64'(resp), 64'h1);
    rd = rdata;
    ufp_rmask = 4'h0;
    ufp_wmask = 4'h0;
    if (|wm) gold[a] = merge(gold_word(a), wd, wm);
  endtask

  task automatic rd_chk(input logic [31:0] a, output int lat);
    logic [31:0] rd;
    do_req(a, 4'(1 + $urandom_range(0, 14)), 4'h0, 32'h0, rd, lat);
    chk($sformatf("rd_%h", a), 64'(rd), 64'(gold_word(a)));
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] m,
                    input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    do_req(a, 4'h0, m, d, rd, lat);
  endtask

  task automatic reset_world();
    @(negedge clk);
    rst = 1'b1;
    ufp_rmask = 4'h0; ufp_wmask = 4'h0; flush_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem.delete(); gold.delete(); ev_q.delete();
  endtask

  task automatic do_flush(output int pulses);
    int cyc;
    bit done;
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    pulses = 0; done = 1'b0; cyc = 0;
    while (!done && cyc < 2000) begin
      if (fdone) begin pulses++; done = 1'b1; end
      @(negedge clk);
      cyc++;
    end
    chk("flush_done", 64'(done), 64'h1);
    chk("flush_pulse_len", 64'(fdone), 64'h0);
  endtask

  task automatic preload_1000();
    logic [255:0] l;
    l = mem_line(32'h1000);
    l[63:32] = 32'hDEADBEEF;
    mem[32'h1000] = l;
  endtask

  initial begin
    logic [31:0] rd, a;
    int lat, p, cyc, r;
    sel = 1'b0; rst = 1'b1; flush_req = 1'b0;
    ufp_addr = '0; ufp_rmask = '0; ufp_wmask = '0; ufp_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_resp", 64'(resp_b | resp_s), 64'h0);
    chk("rst_rdata", 64'(rdata_b | rdata_s), 64'h0);
    chk("rst_dfp", 64'({dread_b, dwrite_b, dread_s, dwrite_s}), 64'h0);
    chk("rst_daddr", 64'(daddr_b | daddr_s), 64'h0);
    chk("rst_fdone", 64'(fdone_b | fdone_s), 64'h0);

    preload_1000();
    do_req(32'h1004, 4'hF, 4'h0, 32'h0, rd, lat);
    chk("cold_rdata", 64'(rd), 64'hDEADBEEF);
    chk("cold_nev", 64'(ev_q.size()), 64'h1);
    chk("cold_ev", 64'(ev_at(0)), 64'({1'b0, 32'h1000, 32'h0}));
    ev_q.delete();
    do_req(32'h1004, 4'hF, 4'h0, 32'h0, rd, lat);
    chk("hit_lat", 64'(lat), 64'h1);
    chk("hit_nev", 64'(ev_q.size()), 64'h0);
    chk("hit_rdata", 64'(rd), 64'hDEADBEEF);

    wr(32'h1004, 4'b0010, 32'h0000AB00);
    do_req(32'h1004, 4'h1, 4'h0, 32'h0, rd, lat);
    chk("st_rdata", 64'(rd), 64'hDEADABEF);
    chk("st_lat", 64'(lat), 64'h1);

    rd_chk(32'h2000, lat);
    rd_chk(32'h3000, lat);
    rd_chk(32'h4000, lat);
    rd_chk(32'h1004, lat);
    rd_chk(32'h4000, lat);
    ev_q.delete();
    rd_chk(32'h5000, lat);
    chk("ev1_nev", 64'(ev_q.size()), 64'h1);
    chk("ev1_ev", 64'(ev_at(0)), 64'({1'b0, 32'h5000, 32'h0}));

    reset_world();
    preload_1000();
    rd_chk(32'h1004, lat);
    wr(32'h1004, 4'b0010, 32'h0000AB00);
    rd_chk(32'h2000, lat);
    rd_chk(32'h3000, lat);
    rd_chk(32'h4000, lat);
    ev_q.delete();
    rd_chk(32'h5000, lat);
    chk("ev2_nev", 64'(ev_q.size()), 64'h2);
    chk("ev2_wb", 64'(ev_at(0)), 64'({1'b1, 32'h1000, 32'hDEADABEF}));
    chk("ev2_fill", 64'(ev_at(1)), 64'({1'b0, 32'h5000, 32'h0}));
    rd_chk(32'h1004, lat);

    reset_world();
    wr(32'h1000, 4'hF, 32'h11112222);
    wr(32'h0020, 4'hF, 32'h33334444);
    ev_q.delete();
    do_flush(p);
    chk("fl_pulses", 64'(p), 64'h1);
    chk("fl_nev", 64'(ev_q.size()), 64'h2);
    chk("fl_ev0", 64'(ev_at(0)), 64'({1'b1, 32'h1000, 32'h5A5A1004}));
    chk("fl_ev1", 64'(ev_at(1)), 64'({1'b1, 32'h0020, 32'h5A5A0024}));
    ev_q.delete();
    rd_chk(32'h1000, lat);
    chk("fl_hit0", 64'(lat), 64'h1);
    rd_chk(32'h0020, lat);
    chk("fl_hit1", 64'(lat), 64'h1);
    chk("fl_quiet", 64'(ev_q.size()), 64'h0);
    for (int i = 2; i < 6; i++) begin
      rd_chk(32'(i) << 12, lat);
      rd_chk((32'(i) << 12) | 32'h20, lat);
    end
    chk("fl_no_wb", 64'(n_writes()), 64'h0);

    reset_world();
    wr(32'h1000, 4'hF, 32'hCAFEF00D);
    rd_chk(32'h2000, lat);
    rd_chk(32'h3000, lat);
    rd_chk(32'h4000, lat);
    @(negedge clk);
    ufp_addr = 32'h5000; ufp_rmask = 4'hF;
    cyc = 0;
    while (!dwrite && cyc < 50) begin @(negedge clk); cyc++; end
    chk("rwb_seen", 64'(dwrite), 64'h1);
    rst = 1'b1;
    ufp_rmask = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    chk("rwb_write", 64'(dwrite), 64'h0);
    chk("rwb_read", 64'(dread), 64'h0);
    chk("rwb_resp", 64'(resp), 64'h0);
    gold.delete(); ev_q.delete();
    rd_chk(32'h1004, lat);
    chk("rwb_miss", 64'(ev_at(0)), 64'({1'b0, 32'h1000, 32'h0}));
    chk("rwb_nowb", 64'(n_writes()), 64'h0);

    sel = 1'b1;
    reset_world();
    rd_chk(32'h000, lat);
    rd_chk(32'h080, lat);
    rd_chk(32'h000, lat);
    ev_q.delete();
    rd_chk(32'h100, lat);
    chk("sm_nev", 64'(ev_q.size()), 64'h1);
    chk("sm_fill", 64'(ev_at(0)), 64'({1'b0, 32'h100, 32'h0}));
    ev_q.delete();
    rd_chk(32'h000, lat);
    chk("sm_hit", 64'(lat), 64'h1);
    chk("sm_hit_nev", 64'(ev_q.size()), 64'h0);
    rd_chk(32'h080, lat);
    chk("sm_evicted", 64'(ev_at(0)), 64'({1'b0, 32'h080, 32'h0}));

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      reset_world();
      for (int i = 0; i < 300; i++) begin
        a = (32'($urandom_range(0, 5)) << 9)
          | (32'($urandom_range(0, 3)) << 5)
          | (32'($urandom_range(0, 7)) << 2);
        r = $urandom_range(0, 19);
        if (r == 0) begin
          do_flush(p);
          chk("rnd_flush", 64'(p), 64'h1);
        end else if (r < 9) begin
          wr(a, 4'($urandom_range(1, 15)), $urandom);
        end else begin
          rd_chk(a, lat);
        end
      end
      do_flush(p);
      foreach (gold[k]) begin
        logic [255:0] l;
        l = mem_line({k[31:5], 5'b0});
        chk($sformatf("clean_%h", k), 64'(l[{k[4:2], 5'b0} +: 32]),
            64'(gold[k]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
